// File: rtl/axis_null_pattern_checker.sv
`default_nettype none
// ============================================================================
// Module      : axis_null_pattern_checker
// Description : Zero-latency AXI-Stream passthrough that checks the null
//               source counting pattern, packet length and EOB placement,
//               and keeps line/packet/burst/error counters plus a capture
//               of the first erroring beat.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_null_pattern_checker #(
    parameter int ITEM_W = 32,   // item width in bits, must be even and <= 64
    parameter int NIPC   = 2     // items per line
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic [15:0]              cfg_lpp,
    input  logic                     cfg_restart_on_eob,
    input  logic [ITEM_W*NIPC-1:0]   s_axis_tdata,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_teob,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [ITEM_W*NIPC-1:0]   m_axis_tdata,
    output logic                     m_axis_tlast,
    output logic                     m_axis_teob,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [31:0]              line_cnt,
    output logic [31:0]              pkt_cnt,
    output logic [31:0]              burst_cnt,
    output logic [31:0]              err_cnt,
    output logic                     err_sticky,
    output logic                     first_err_valid,
    output logic [31:0]              first_err_line,
    output logic [ITEM_W*NIPC-1:0]   first_err_data,
    output logic [1:0]               first_err_type
);

    localparam int c_W    = ITEM_W * NIPC;
    localparam int c_HALF = ITEM_W / 2;

    typedef enum logic [0:0] {
        IN_IDLE = 1'b0,
        IN_PKT  = 1'b1
    } pkt_state_t;

    pkt_state_t          r_state;
    logic [31:0]         r_exp_idx;
    logic [15:0]         r_beat_idx;
    logic [31:0]         r_line_cnt;
    logic [31:0]         r_pkt_cnt;
    logic [31:0]         r_burst_cnt;
    logic [31:0]         r_err_cnt;
    logic                r_err_sticky;
    logic                r_first_err_valid;
    logic [31:0]         r_first_err_line;
    logic [c_W-1:0]      r_first_err_data;
    logic [1:0]          r_first_err_type;

    logic                w_beat;
    logic [c_HALF-1:0]   w_idx_half;
    logic [c_W-1:0]      w_exp_line;
    logic [15:0]         w_beat_pos;
    logic [15:0]         w_beat_pos_next;
    logic                w_data_err;
    logic                w_len_err;
    logic                w_any_err;
    logic                w_restart;

    // Passthrough is purely combinational; backpressure goes straight upstream.
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_teob   = s_axis_teob;
    assign m_axis_tvalid = s_axis_tvalid;
    assign s_axis_tready = m_axis_tready;

    assign w_beat     = s_axis_tvalid & m_axis_tready;
    assign w_idx_half = r_exp_idx[c_HALF-1:0];

    // Every item of the expected line is {~idx, idx} over the low half-width.
    generate
        for (genvar g = 0; g < NIPC; g++) begin : g_lane
            assign w_exp_line[g*ITEM_W +: ITEM_W] = {~w_idx_half, w_idx_half};
        end
    endgenerate

    // Outside a packet the beat position is 0 regardless of the counter.
    assign w_beat_pos      = (r_state == IN_IDLE) ? 16'd0 : r_beat_idx;
    assign w_beat_pos_next = w_beat_pos + 16'd1;

    assign w_data_err = (s_axis_tdata != w_exp_line);
    assign w_len_err  = s_axis_tlast && (cfg_lpp != 16'd0) &&
                        (w_beat_pos_next != cfg_lpp);
    assign w_any_err  = w_data_err | w_len_err;
    assign w_restart  = s_axis_tlast && s_axis_teob && cfg_restart_on_eob;

    // Checker state, counters and first-error capture; clear behaves as rst
    // and takes priority over a coincident beat.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state           <= IN_IDLE;
            r_exp_idx         <= 32'd0;
            r_beat_idx        <= 16'd0;
            r_line_cnt        <= 32'd0;
            r_pkt_cnt         <= 32'd0;
            r_burst_cnt       <= 32'd0;
            r_err_cnt         <= 32'd0;
            r_err_sticky      <= 1'b0;
            r_first_err_valid <= 1'b0;
            r_first_err_line  <= 32'd0;
            r_first_err_data  <= '0;
            r_first_err_type  <= 2'b00;
        end else if (w_beat) begin
            r_exp_idx  <= w_restart ? 32'd0 : r_exp_idx + 32'd1;
            r_line_cnt <= r_line_cnt + 32'd1;

            if (s_axis_tlast) begin
                r_pkt_cnt  <= r_pkt_cnt + 32'd1;
                r_beat_idx <= 16'd0;
                r_state    <= IN_IDLE;
                if (s_axis_teob) begin
                    r_burst_cnt <= r_burst_cnt + 32'd1;
                end
            end else begin
                r_beat_idx <= w_beat_pos_next;
                r_state    <= IN_PKT;
            end

            if (w_any_err) begin
                r_err_sticky <= 1'b1;
                if (r_err_cnt != 32'hFFFF_FFFF) begin
                    r_err_cnt <= r_err_cnt + 32'd1;
                end
                if (!r_first_err_valid) begin
                    r_first_err_valid <= 1'b1;
                    r_first_err_line  <= r_line_cnt;
                    r_first_err_data  <= s_axis_tdata;
                    r_first_err_type  <= {w_len_err, w_data_err};
                end
            end
        end
    end

    assign line_cnt        = r_line_cnt;
    assign pkt_cnt         = r_pkt_cnt;
    assign burst_cnt       = r_burst_cnt;
    assign err_cnt         = r_err_cnt;
    assign err_sticky      = r_err_sticky;
    assign first_err_valid = r_first_err_valid;
    assign first_err_line  = r_first_err_line;
    assign first_err_data  = r_first_err_data;
    assign first_err_type  = r_first_err_type;

endmodule
`default_nettype wire

// File: tb/tb_axis_null_pattern_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_null_pattern_checker
// Description : Scoreboard bench for axis_null_pattern_checker. The driver
//               queues each issued beat; a monitor pops and compares on each
//               output handshake. Status outputs are checked against
//               hand-computed constants after each scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_null_pattern_checker;

    localparam int c_W = 64;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           clear = 1'b0;
    logic [15:0]    cfg_lpp = 16'd0;
    logic           cfg_restart_on_eob = 1'b0;
    logic [c_W-1:0] s_axis_tdata = '0;
    logic           s_axis_tlast = 1'b0;
    logic           s_axis_teob = 1'b0;
    logic           s_axis_tvalid = 1'b0;
    logic           s_axis_tready;
    logic [c_W-1:0] m_axis_tdata;
    logic           m_axis_tlast;
    logic           m_axis_teob;
    logic           m_axis_tvalid;
    logic           m_axis_tready = 1'b1;
    logic [31:0]    line_cnt, pkt_cnt, burst_cnt, err_cnt;
    logic           err_sticky, first_err_valid;
    logic [31:0]    first_err_line;
    logic [c_W-1:0] first_err_data;
    logic [1:0]     first_err_type;

    int  checks = 0;
    int  failures = 0;
    bit  rand_ready = 1'b0;
    logic [c_W+1:0] exp_q[$];

    axis_null_pattern_checker #(.ITEM_W(32), .NIPC(2)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .cfg_lpp(cfg_lpp), .cfg_restart_on_eob(cfg_restart_on_eob),
        .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
        .s_axis_teob(s_axis_teob), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_teob(m_axis_teob), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .line_cnt(line_cnt), .pkt_cnt(pkt_cnt), .burst_cnt(burst_cnt),
        .err_cnt(err_cnt), .err_sticky(err_sticky),
        .first_err_valid(first_err_valid), .first_err_line(first_err_line),
        .first_err_data(first_err_data), .first_err_type(first_err_type)
    );

    always #5 clk = ~clk;

    // Reference pattern: two items of {~i[15:0], i[15:0]}.
    function automatic logic [c_W-1:0] line(input int unsigned i);
        logic [31:0] v;
        logic [15:0] lo;
        v  = i;
        lo = v[15:0];
        return {~lo, lo, ~lo, lo};
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready: either always 1 or randomly throttled (~75%).
    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: compare each output handshake against the queued beat.
    initial begin
        logic [c_W+1:0] e;
        forever begin
            @(negedge clk);
            if (m_axis_tvalid && m_axis_tready) begin
                check("s_tready_pass", {63'd0, s_axis_tready}, {63'd0, m_axis_tready});
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: got output beat %0h expected none", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("pass_data", m_axis_tdata, e[c_W+1:2]);
                    check("pass_flags", {62'd0, m_axis_tlast, m_axis_teob}, {62'd0, e[1:0]});
                end
            end
        end
    end

    task automatic send(input logic [c_W-1:0] d, input logic l, input logic e,
                        input logic c);
        int waited;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_teob   = e;
        s_axis_tvalid = 1'b1;
        clear         = c;
        exp_q.push_back({d, l, e});
        waited = 0;
        forever begin
            @(posedge clk);
            if (m_axis_tready) break;
            waited++;
            if (waited > 1000) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: got no handshake in %0d cycles expected one", waited);
                void'(exp_q.pop_back());
                break;
            end
        end
        #1;
        s_axis_tvalid = 1'b0;
        clear         = 1'b0;
    endtask

    task automatic send_pkt(input int start, input int n, input bit eob,
                            input int bad);
        for (int k = 0; k < n; k++) begin
            logic [c_W-1:0] d;
            d = line(start + k);
            if (start + k == bad) d = d ^ 64'd1;
            send(d, k == n - 1, eob && (k == n - 1), 1'b0);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (3) @(posedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        check("rst_line_cnt", line_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_sticky", {63'd0, err_sticky}, 0);
        check("rst_fev", {63'd0, first_err_valid}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Good stream, throttled
        rand_ready = 1'b1;
        cfg_lpp = 16'd101;
        for (int p = 0; p < 5; p++) send_pkt(p * 101, 101, p == 4, -1);
        drain("good_drain");
        check("good_line_cnt", line_cnt, 505);
        check("good_pkt_cnt", pkt_cnt, 5);
        check("good_burst_cnt", burst_cnt, 1);
        check("good_err_cnt", err_cnt, 0);
        check("good_sticky", {63'd0, err_sticky}, 0);

        // Corrupt line 150
        do_clear();
        check("clr_line_cnt", line_cnt, 0);
        send_pkt(0, 101, 1'b0, 150);
        send_pkt(101, 101, 1'b0, 150);
        drain("corrupt_drain");
        check("corrupt_err_cnt", err_cnt, 1);
        check("corrupt_fev", {63'd0, first_err_valid}, 1);
        check("corrupt_line", first_err_line, 150);
        check("corrupt_type", {62'd0, first_err_type}, 1);
        check("corrupt_data", first_err_data, line(150) ^ 64'd1);
        check("corrupt_sticky", {63'd0, err_sticky}, 1);
        rand_ready = 1'b0;

        // Short packet, length check on and off
        do_clear();
        send_pkt(0, 100, 1'b0, -1);
        check("short_err_cnt", err_cnt, 1);
        check("short_type", {62'd0, first_err_type}, 2);
        check("short_line", first_err_line, 99);
        check("short_pkt_cnt", pkt_cnt, 1);
        do_clear();
        cfg_lpp = 16'd0;
        send_pkt(0, 100, 1'b0, -1);
        check("nolen_err_cnt", err_cnt, 0);
        check("nolen_pkt_cnt", pkt_cnt, 1);

        // Restart on EOB
        do_clear();
        cfg_restart_on_eob = 1'b1;
        send_pkt(0, 10, 1'b1, -1);
        send_pkt(0, 10, 1'b1, -1);
        check("restart_err_cnt", err_cnt, 0);
        check("restart_burst_cnt", burst_cnt, 2);
        do_clear();
        cfg_restart_on_eob = 1'b0;
        send_pkt(0, 10, 1'b1, -1);
        send_pkt(0, 10, 1'b1, -1);
        check("norestart_err_cnt", err_cnt, 10);
        check("norestart_line", first_err_line, 10);
        check("norestart_type", {62'd0, first_err_type}, 1);

        // Data and length error on the same beat count once
        do_clear();
        cfg_lpp = 16'd4;
        send_pkt(0, 3, 1'b0, 2);
        check("both_err_cnt", err_cnt, 1);
        check("both_type", {62'd0, first_err_type}, 3);

        // Clear coincident with a mid-packet beat
        send(line(3), 1'b0, 1'b0, 1'b0);
        send(line(4), 1'b0, 1'b0, 1'b0);
        send(line(5), 1'b0, 1'b0, 1'b1);
        check("cclr_line_cnt", line_cnt, 0);
        check("cclr_err_cnt", err_cnt, 0);
        check("cclr_sticky", {63'd0, err_sticky}, 0);
        check("cclr_fev", {63'd0, first_err_valid}, 0);
        send_pkt(0, 4, 1'b0, -1);
        check("cclr_after_line", line_cnt, 4);
        check("cclr_after_pkt", pkt_cnt, 1);
        check("cclr_after_err", err_cnt, 0);
        send(line(99), 1'b0, 1'b0, 1'b0);
        check("cclr_post_sticky", {63'd0, err_sticky}, 1);
        check("cclr_post_line", first_err_line, 4);
        drain("cclr_drain");

        // Index wrap across 0xFFFF -> 0x0000
        do_clear();
        cfg_lpp = 16'd0;
        for (int n = 0; n < 65540; n++) begin
            send(line(n), (n % 1000 == 999) || (n == 65539), 1'b0, 1'b0);
        end
        drain("wrap_drain");
        check("wrap_err_cnt", err_cnt, 0);
        check("wrap_line_cnt", line_cnt, 65540);
        check("wrap_pkt_cnt", pkt_cnt, 66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
